// File: rtl/fifo_reader.sv
// Read-side engine for a 16x8 synchronous FIFO: issues reads, absorbs the one-cycle
// read latency in a 2-entry skid buffer and streams bytes out on valid/ready.
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_re,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state_r, state_s;
  logic [1:0]        occ_r, occ_s;
  logic              pend_r, pend_s;
  logic [DATA_W-1:0] buf0_r, buf0_s;
  logic [DATA_W-1:0] buf1_r, buf1_s;
  logic [CNT_W-1:0]  count_r;
  logic              pop_s;
  logic              re_s;
  logic [2:0]        level_s;

  // Projected occupancy after this edge; a new read is only allowed if it still fits.
  assign pop_s   = (occ_r != 2'd0) & m_ready;
  assign level_s = {1'b0, occ_r} + {2'b00, pend_r} - {2'b00, pop_s};
  assign re_s    = rst & (state_r == ST_RUN) & en & ~flush & ~fifo_empty & (level_s <= 3'd1);

  assign fifo_re  = re_s;
  assign m_data   = buf0_r;
  assign m_valid  = (occ_r != 2'd0);
  assign busy     = (occ_r != 2'd0) | pend_r;
  assign rd_count = count_r;

  // Next-state for FSM, skid buffer and pending-read flag; flush overrides everything.
  always_comb begin
    state_s = state_r;
    occ_s   = occ_r;
    pend_s  = pend_r;
    buf0_s  = buf0_r;
    buf1_s  = buf1_r;
    if (flush) begin
      state_s = ST_FLUSH;
      occ_s   = 2'd0;
      pend_s  = 1'b0;
    end else begin
      pend_s = re_s;
      occ_s  = level_s[1:0];
      case ({pend_r, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            buf0_s = fifo_dout;
          end else begin
            buf1_s = fifo_dout;
          end
        end
        2'b01: buf0_s = buf1_r;
        2'b11: begin
          // Head leaves while a word lands: it goes straight to the head if the buffer held one.
          if (occ_r == 2'd1) begin
            buf0_s = fifo_dout;
          end else begin
            buf0_s = buf1_r;
            buf1_s = fifo_dout;
          end
        end
        default: buf0_s = buf0_r;
      endcase
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!en && (occ_r == 2'd0) && !pend_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          occ_s  = 2'd0;
          pend_s = 1'b0;
          if (en) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, buffer and delivered-byte counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      occ_r   <= 2'd0;
      pend_r  <= 1'b0;
      buf0_r  <= {DATA_W{1'b0}};
      buf1_r  <= {DATA_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      occ_r   <= occ_s;
      pend_r  <= pend_s;
      buf0_r  <= buf0_s;
      buf1_r  <= buf1_s;
      if (!flush && pop_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule
